// File: rtl/dcounter_core.sv
// BCD countdown timer core: loads a sanitised MM:SS.cc preset and decrements it once per CLK_DIV-cycle tick.
// Optional build macro DCOUNTER_AUTO_RELOAD_EN: reload the preset on expiry instead of holding 00:00.00.
module dcounter_core #(
  parameter int CLK_DIV = 1000000
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic       time_out
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [23:0]     r_cnt;
  logic [23:0]     w_cnt_nxt;
  logic [23:0]     r_pre;
  logic [23:0]     w_pre_nxt;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic            r_time_out;
  logic            w_time_out_nxt;
  logic [23:0]     w_load_val;
  logic            w_load_zero;
  logic [23:0]     w_dec;
  logic            w_dec_zero;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    if (d > lim) begin
      clamp_digit = lim;
    end else begin
      clamp_digit = d;
    end
  endfunction

  function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [3:0] tens_max);
    sanitize = {clamp_digit(v[7:4], tens_max), clamp_digit(v[3:0], 4'd9)};
  endfunction

  // Digits from LSB: ms units, ms tens, sec units, sec tens, min units, min tens.
  function automatic logic [23:0] bcd_dec(input logic [23:0] c);
    logic [23:0] r;
    logic        borrow;
    r      = c;
    borrow = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (borrow) begin
        if (r[k*4 +: 4] == 4'd0) begin
          r[k*4 +: 4] = ((k == 3) || (k == 5)) ? 4'd5 : 4'd9;
          borrow      = 1'b1;
        end else begin
          r[k*4 +: 4] = r[k*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        borrow = 1'b0;
      end
    end
    bcd_dec = r;
  endfunction

  assign w_load_val  = {sanitize(min_i, 4'd5), sanitize(sec_i, 4'd5), sanitize(ms_10_i, 4'd9)};
  assign w_load_zero = (w_load_val == 24'd0);
  assign w_dec       = bcd_dec(r_cnt);
  assign w_dec_zero  = (w_dec == 24'd0);

  // Next-state, count, prescaler and expiry flag; load outranks any tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pre_nxt      = r_pre;
    w_presc_nxt    = r_presc;
    w_time_out_nxt = r_time_out;
    if (load) begin
      w_pre_nxt   = w_load_val;
      w_cnt_nxt   = w_load_val;
      w_presc_nxt = '0;
      if (w_load_zero) begin
        w_state_nxt    = DONE;
        w_time_out_nxt = 1'b1;
      end else begin
        w_state_nxt    = RUN;
        w_time_out_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt      = 24'd0;
          w_presc_nxt    = '0;
          w_time_out_nxt = 1'b0;
        end
        RUN: begin
          w_time_out_nxt = 1'b0;
          if (en) begin
            if (r_presc == PRESC_MAX) begin
              w_presc_nxt = '0;
              if (w_dec_zero) begin
                w_time_out_nxt = 1'b1;
`ifdef DCOUNTER_AUTO_RELOAD_EN
                w_cnt_nxt   = r_pre;
                w_state_nxt = RUN;
`else
                w_cnt_nxt   = 24'd0;
                w_state_nxt = DONE;
`endif
              end else begin
                w_cnt_nxt = w_dec;
              end
            end else begin
              w_presc_nxt = r_presc + PRESC_ONE;
            end
          end else begin
            w_presc_nxt = r_presc;
          end
        end
        DONE: begin
          w_cnt_nxt      = 24'd0;
          w_presc_nxt    = '0;
          w_time_out_nxt = 1'b1;
        end
        default: begin
          w_state_nxt    = IDLE;
          w_cnt_nxt      = 24'd0;
          w_presc_nxt    = '0;
          w_time_out_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 24'd0;
      r_pre      <= 24'd0;
      r_presc    <= '0;
      r_time_out <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pre      <= w_pre_nxt;
      r_presc    <= w_presc_nxt;
      r_time_out <= w_time_out_nxt;
    end
  end

  assign min_o    = r_cnt[23:16];
  assign sec_o    = r_cnt[15:8];
  assign ms_10_o  = r_cnt[7:0];
  assign time_out = r_time_out;

endmodule

// File: tb/tb_dcounter_core.sv
// Self-checking bench for dcounter_core: vector table, hand sequences, and random run against an integer model.
module tb_dcounter_core;
  localparam int CLK_DIV = 4;

  logic       clk_core = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] min_i;
  logic [7:0] sec_i;
  logic [7:0] ms_10_i;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic [7:0] ms_10_o;
  logic       time_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_core = ~clk_core;

  dcounter_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk_core(clk_core), .rst(rst), .en(en), .load(load),
    .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
    .min_o(min_o), .sec_o(sec_o), .ms_10_o(ms_10_o), .time_out(time_out)
  );

  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] mi, si, msi;
    logic [24:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [24:0] outs();
    return {min_o, sec_o, ms_10_o, time_out};
  endfunction

  task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic void add(input logic ld, input logic e, input logic [7:0] mi, input logic [7:0] si,
                              input logic [7:0] msi, input logic [24:0] exp);
    vec_t v;
    v.ld = ld; v.en = e; v.mi = mi; v.si = si; v.msi = msi; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic ld, input logic e, input logic [7:0] mi, input logic [7:0] si, input logic [7:0] msi);
    load = ld; en = e; min_i = mi; sec_i = si; ms_10_i = msi;
  endtask

  // Behavioural model: remaining time as an integer count of 10 ms units.
  int rem, preset, pcnt;
  bit running, m_to;

  function automatic int clampi(input logic [3:0] d, input int lim);
    return (int'(d) > lim) ? lim : int'(d);
  endfunction

  function automatic int to_units(input logic [7:0] mi, input logic [7:0] si, input logic [7:0] msi);
    int m, s, c;
    m = clampi(mi[7:4], 5) * 10 + clampi(mi[3:0], 9);
    s = clampi(si[7:4], 5) * 10 + clampi(si[3:0], 9);
    c = clampi(msi[7:4], 9) * 10 + clampi(msi[3:0], 9);
    return m * 6000 + s * 100 + c;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [24:0] model_outs();
    return {to_bcd(rem / 6000), to_bcd((rem / 100) % 60), to_bcd(rem % 100), m_to};
  endfunction

  function automatic void model_step();
    if (load) begin
      preset  = to_units(min_i, sec_i, ms_10_i);
      rem     = preset;
      pcnt    = 0;
      running = (preset != 0);
      m_to    = (preset == 0);
    end else if (running) begin
      m_to = 1'b0;
      if (en) begin
        pcnt++;
        if (pcnt == CLK_DIV) begin
          pcnt = 0;
          rem--;
          if (rem == 0) begin
            m_to = 1'b1;
`ifdef DCOUNTER_AUTO_RELOAD_EN
            rem = preset;
`else
            running = 1'b0;
`endif
          end
        end
      end
    end
  endfunction

  logic [24:0] exp_expire;
  logic [24:0] exp_after;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk_core);
    #1;
    check("reset_state", outs(), 25'd0);
    rst = 1'b0;

`ifdef DCOUNTER_AUTO_RELOAD_EN
    exp_expire = {8'h00, 8'h00, 8'h03, 1'b1};
    exp_after  = {8'h00, 8'h00, 8'h03, 1'b0};
`else
    exp_expire = {8'h00, 8'h00, 8'h00, 1'b1};
    exp_after  = {8'h00, 8'h00, 8'h00, 1'b1};
`endif
    // Full countdown from 00:00.03.
    add(1'b1, 1'b1, 8'h00, 8'h00, 8'h03, {24'h000003, 1'b0});
    for (int i = 1; i < 12; i++) begin
      add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, {16'h0000, to_bcd(3 - i / 4), 1'b0});
    end
    add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, exp_expire);
    add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, exp_after);
    // Borrow chain from 10:00.00.
    add(1'b1, 1'b1, 8'h10, 8'h00, 8'h00, {24'h100000, 1'b0});
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, {24'h100000, 1'b0});
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, {24'h095999, 1'b0});
    // Load on the exact tick cycle wins and restarts the prescaler.
    add(1'b1, 1'b1, 8'h00, 8'h05, 8'h00, {24'h000500, 1'b0});
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, {24'h000500, 1'b0});
    add(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, {24'h000499, 1'b0});
    // Zero preset and clamping.
    add(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, {24'h000000, 1'b1});
    add(1'b1, 1'b1, 8'h00, 8'h7C, 8'h00, {24'h005900, 1'b0});
    add(1'b1, 1'b0, 8'hFF, 8'hAA, 8'hFA, {24'h595999, 1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].en, vecs[i].mi, vecs[i].si, vecs[i].msi);
      @(posedge clk_core);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Enable pause: tick lands 2 enabled cycles after resume.
    drive(1'b1, 1'b1, 8'h00, 8'h01, 8'h00);
    @(posedge clk_core); #1;
    check("pause_load", outs(), {24'h000100, 1'b0});
    drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_core); #1;
      check("pause_run", outs(), (i >= 4) ? {24'h000099, 1'b0} : {24'h000100, 1'b0});
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_core); #1;
      check("pause_hold", outs(), {24'h000099, 1'b0});
    end
    en = 1'b1;
    @(posedge clk_core); #1;
    check("resume_1", outs(), {24'h000099, 1'b0});
    @(posedge clk_core); #1;
    check("resume_2", outs(), {24'h000098, 1'b0});

    // Asynchronous reset mid-run.
    #2 rst = 1'b1;
    #1 check("async_reset", outs(), 25'd0);
    repeat (2) @(posedge clk_core);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_core); #1;
      check("idle_after_reset", outs(), 25'd0);
    end

    // Random stimulus against the model.
    rst = 1'b1;
    @(posedge clk_core); #1;
    rst = 1'b0;
    rem = 0; preset = 0; pcnt = 0; running = 1'b0; m_to = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      load = ($urandom_range(0, 79) == 0);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        min_i = 8'($urandom_range(0, 255)); sec_i = 8'($urandom_range(0, 255)); ms_10_i = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 7) == 0) begin
        min_i = 8'h00; sec_i = 8'h00; ms_10_i = 8'h00;
      end else begin
        min_i = 8'h00; sec_i = 8'h00;
        ms_10_i = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      end
      model_step();
      @(posedge clk_core); #1;
      check("random", outs(), model_outs());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
